mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Parametrised arbiter that shares one memory port among NUM_CH requesters, such as icache refill and data MEM stage.
- Each channel and the memory side use valid/ready request handshakes with a valid-only response channel.
- One transaction is outstanding at a time.
- Arbitration is fixed priority or round-robin, selected by parameter.
- A watchdog terminates responses that never arrive.

Parameters:
NUM_CH, 2, number of requesting channels (2..8); channel 0 = lowest index
ADDR_W, 64, address width
DATA_W, 64, data width
MASK_W, 4, byte-mask/size field width, passed through unmodified
RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin
TIMEOUT, 256, max cycles waiting for mem_resp_valid; 0 disables the watchdog

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (asserted when 0)
req_valid  in  NUM_CH  per-channel request valid
req_ready  out  NUM_CH  per-channel request accepted
req_wen  in  NUM_CH  1 = write
req_addr  in  NUM_CH*ADDR_W  flattened addresses, channel i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_CH*DATA_W  flattened write data
req_mask  in  NUM_CH*MASK_W  flattened masks
resp_valid  out  NUM_CH  one-cycle response pulse to the owning channel
resp_rdata  out  DATA_W  read data, shared bus, valid with resp_valid
resp_err  out  1  response terminated by watchdog, valid with resp_valid
mem_req_valid  out  1  downstream request valid
mem_req_ready  in  1  downstream accepts request
mem_wen  out  1  downstream write enable
mem_addr  out  ADDR_W  downstream address
mem_wdata  out  DATA_W  downstream write data
mem_mask  out  MASK_W  downstream mask
mem_resp_valid  in  1  downstream response (reads and writes)
mem_rdata  in  DATA_W  downstream read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async) forces these values:
  - FSM = IDLE; rr_ptr = 0; grant register = 0.
  - Latched payload = 0; watchdog counter = 0.
  - All outputs 0.
- Reset mid-transaction abandons the transaction.
  - No resp_valid is issued for it.
  - A late mem_resp_valid after reset release while in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner g is computed combinationally from req_valid.
  - RR_MODE=0: lowest asserted index wins.
  - RR_MODE=1: first asserted index at or after rr_ptr, wrapping modulo NUM_CH.
  - req_ready[g]=1 only. All other req_ready are 0. All req_ready are 0 outside IDLE.
  - On the handshake:
    - Latch g, req_wen, addr, wdata and mask of channel g.
    - rr_ptr <= (g+1) mod NUM_CH.
    - Next state ISSUE.
  - No req_valid: stay in IDLE.
- ISSUE:
  - mem_req_valid=1.
  - mem_wen, mem_addr, mem_wdata and mem_mask come from the latch and are stable until accepted.
  - On mem_req_ready=1: go to WAIT, clear the watchdog.
  - mem_resp_valid in the same cycle as mem_req_ready is not legal for the memory side; the arbiter ignores it.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid: latch mem_rdata (latch 0 for writes), err=0, go to RESP.
  - Otherwise, if TIMEOUT!=0: counter increments.
    - When counter == TIMEOUT-1 and there is still no response: rdata=0, err=1, go to RESP.
  - If the response and the timeout expiry land in the same cycle, the response wins (err=0).
- RESP:
  - resp_valid[g]=1 for exactly one cycle, with resp_rdata and resp_err from the latch.
  - Next state IDLE.
  - resp_rdata/resp_err hold their last values otherwise. Only resp_valid qualifies them.
- Latency:
  - Minimum from req_valid&req_ready to resp_valid is 3 cycles: ISSUE accepted immediately, response the next cycle.
  - The next grant happens in the cycle after RESP. Back-to-back throughput is one transaction per 4 cycles minimum.
- Fairness:
  - RR_MODE=1: every continuously requesting channel is granted within NUM_CH transactions.
  - RR_MODE=0: starvation of high indices is permitted.
- Requesters are required to hold req_valid and payload stable until req_ready; the arbiter does not check this.
- Counter width is clog2(TIMEOUT+1). TIMEOUT=0 means WAIT never times out.

Test Plan:
- Single read:
  - Stimulus: NUM_CH=2, ch1 read addr 0x8000_0010; memory ready immediately, responds 1 cycle later with 0xDEAD_BEEF_0000_1234.
  - Required: req_ready[1] in cycle 0; mem_req_valid cycle 1 with mem_addr=0x8000_0010, mem_wen=0; resp_valid=2'b10 cycle 3 with rdata 0xDEAD_BEEF_0000_1234, err=0.
- Fixed priority:
  - Stimulus: RR_MODE=0, both channels request continuously for 4 transactions.
  - Required: all 4 grants go to ch0; ch1 is never granted.
- Round-robin:
  - Stimulus: RR_MODE=1, NUM_CH=4, all channels request continuously.
  - Required: grant order 0,1,2,3,0. With only ch2 and ch0 requesting after rr_ptr=3, the order is 0,2,0.
- Write with backpressure:
  - Stimulus: ch0 write wdata=0x11, mask=4'b1111; mem_req_ready held 0 for 5 cycles.
  - Required: mem_req_valid and payload stay stable for all 5 cycles; one mem handshake; resp_valid[0] after mem_resp_valid with rdata=0, err=0.
- Timeout:
  - Stimulus: TIMEOUT=8, memory accepts but never responds.
  - Required: resp_valid pulse with err=1, rdata=0 exactly 8 cycles after entering WAIT, then IDLE.
  - Corner: a response arriving on the 8th WAIT cycle gives err=0 instead.
- Async reset:
  - Stimulus: assert rst=0 mid-WAIT between clock edges.
  - Required: busy, mem_req_valid, req_ready and resp_valid are 0 immediately; no resp_valid afterwards; the first post-reset grant under RR_MODE=1 goes to ch0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between NUM_CH requesters, the arbiter and one memory port.
// The arbiter takes the slave view; the requesters plus memory model take the master view.
interface mem_port_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int MASK_W = 4
);
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        req_wen;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_wdata;
    logic [NUM_CH*MASK_W-1:0] req_mask;
    logic [NUM_CH-1:0]        resp_valid;
    logic [DATA_W-1:0]        resp_rdata;
    logic                     resp_err;
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic                     mem_wen;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [MASK_W-1:0]        mem_mask;
    logic                     mem_resp_valid;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     busy;

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_mask,
               mem_req_ready, mem_resp_valid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_mask, busy
    );

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_mask,
               mem_req_ready, mem_resp_valid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_mask, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among NUM_CH requesters, one transaction in flight,
// fixed-priority or round-robin grant, with a response watchdog.
module mem_port_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MASK_W  = 4,
    parameter int RR_MODE = 0,
    parameter int TIMEOUT = 256
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    // state | meaning
    // IDLE  | grant offered to the winning requester
    // ISSUE | latched request presented to memory
    // WAIT  | request accepted, waiting for response or watchdog
    // RESP  | one-cycle response pulse to the owning channel

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    gnt_q;
    logic                wen_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   mask_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                mem_req_valid_q;
    logic [NUM_CH-1:0]   resp_valid_q;
    logic                busy_q;

    logic [IDX_W-1:0]    win_d;
    logic                win_found_d;
    logic [IDX_W:0]      cand_d;

    // Scan from rr_ptr (or from 0 in fixed priority), wrapping at NUM_CH.
    always_comb begin
        win_d       = '0;
        win_found_d = 1'b0;
        cand_d      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand_d = (RR_MODE != 0) ? ({1'b0, rr_ptr_q} + (IDX_W+1)'(i)) : (IDX_W+1)'(i);
            if (cand_d >= (IDX_W+1)'(NUM_CH))
                cand_d = cand_d - (IDX_W+1)'(NUM_CH);
            if (!win_found_d && bus.req_valid[cand_d[IDX_W-1:0]]) begin
                win_found_d = 1'b1;
                win_d       = cand_d[IDX_W-1:0];
            end
        end
    end

    // Gated by rst so no grant is offered while reset is held.
    assign bus.req_ready = (state_q == IDLE && rst && win_found_d) ?
                           (NUM_CH'(1) << win_d) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            rr_ptr_q        <= '0;
            gnt_q           <= '0;
            wen_q           <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            mask_q          <= '0;
            rdata_q         <= '0;
            err_q           <= 1'b0;
            cnt_q           <= '0;
            mem_req_valid_q <= 1'b0;
            resp_valid_q    <= '0;
            busy_q          <= 1'b0;
        end else begin
            resp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        gnt_q           <= win_d;
                        wen_q           <= bus.req_wen[win_d];
                        addr_q          <= bus.req_addr[win_d*ADDR_W +: ADDR_W];
                        wdata_q         <= bus.req_wdata[win_d*DATA_W +: DATA_W];
                        mask_q          <= bus.req_mask[win_d*MASK_W +: MASK_W];
                        rr_ptr_q        <= (win_d == IDX_W'(NUM_CH - 1)) ? '0 : win_d + 1'b1;
                        mem_req_valid_q <= 1'b1;
                        busy_q          <= 1'b1;
                        state_q         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        cnt_q           <= '0;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_resp_valid) begin
                        rdata_q      <= wen_q ? '0 : bus.mem_rdata;
                        err_q        <= 1'b0;
                        resp_valid_q <= NUM_CH'(1) << gnt_q;
                        state_q      <= RESP;
                    end else if (TIMEOUT != 0) begin
                        if (cnt_q == CNT_TC) begin
                            rdata_q      <= '0;
                            err_q        <= 1'b1;
                            resp_valid_q <= NUM_CH'(1) << gnt_q;
                            state_q      <= RESP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_mask      = mask_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = rdata_q;
    assign bus.resp_err      = err_q;
    assign bus.busy          = busy_q;
endmodule
